// File: rtl/r_bus_arb_pkg.sv
// Shared types and the round-robin pick helper for the RAM read-bus arbiter.
// The helper is sized for up to MAX_CH requesters, so the write-port arbiter can reuse it.
package r_bus_arb_pkg;

   localparam int MAX_CH   = 16;
   localparam int MAX_CH_W = 4;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t GRANT = 2'd1;
   localparam state_t RESP  = 2'd2;

   typedef struct packed {
      logic                found;
      logic [MAX_CH_W-1:0] idx;
   } rr_pick_t;

   // First set request after 'last', wrapping modulo num_ch.
   function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]   req,
                                        input logic [MAX_CH_W-1:0] last,
                                        input int                  num_ch);
      rr_pick_t            res;
      logic [MAX_CH_W-1:0] ci;
      res = '0;
      for (int k = 1; k <= MAX_CH; k++) begin
         ci = MAX_CH_W'((int'(last) + k) % num_ch);
         if (k <= num_ch && !res.found && req[ci]) begin
            res.found = 1'b1;
            res.idx   = ci;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/r_bus_arbiter_rr.sv
// Round-robin picker: combinational choice from the request vector plus the
// registered last-served pointer, which advances only when the pick is taken.
module rr_arbiter
   import r_bus_arb_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   localparam int LB_NUM_CH = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [NUM_CH-1:0]    req,
   input  logic                 load,
   output logic                 found,
   output logic [LB_NUM_CH-1:0] idx
);

   logic [LB_NUM_CH-1:0] last_q;
   rr_pick_t             pick;

   always_comb begin
      pick = rr_pick(MAX_CH'(req), MAX_CH_W'(last_q), NUM_CH);
   end

   assign found = pick.found;
   assign idx   = LB_NUM_CH'(pick.idx);

   // Pointer starts at the top channel so channel 0 wins the first arbitration.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         last_q <= LB_NUM_CH'(NUM_CH - 1);
      end else if (load && found) begin
         last_q <= idx;
      end
   end

endmodule

// File: rtl/r_bus_arbiter.sv
// N-channel round-robin arbiter in front of a single RAM read slave.
// Optional slave-response timeout is compiled in with `define R_BUS_ARB_TIMEOUT_EN.
module r_bus_arbiter
   import r_bus_arb_pkg::*;
#(
   parameter  int DATA_WIDTH     = 32,
   parameter  int RAM_DEPTH      = 256,
   parameter  int NUM_CH         = 4,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int LB_RAM_DEPTH   = $clog2(RAM_DEPTH),
   localparam int LB_NUM_CH      = $clog2(NUM_CH)
) (
   input  logic                                 clk,
   input  logic                                 n_rst,
   input  logic [NUM_CH-1:0]                    m_valid,
   input  logic [NUM_CH-1:0][LB_RAM_DEPTH-1:0]  m_addr,
   output logic [NUM_CH-1:0]                    m_ready,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    m_data,
   output logic                                 s_valid,
   output logic [LB_RAM_DEPTH-1:0]              s_addr,
   input  logic                                 s_ready,
   input  logic [DATA_WIDTH-1:0]                s_data,
   output logic [LB_NUM_CH-1:0]                 grant_id,
   output logic                                 busy,
   output logic                                 timeout_err
);

   state_t               state;
   logic                 pick_found;
   logic [LB_NUM_CH-1:0] pick_idx;
   logic                 to_hit;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
      .clk   (clk),
      .n_rst (n_rst),
      .req   (m_valid),
      .load  (state == IDLE),
      .found (pick_found),
      .idx   (pick_idx)
   );

`ifdef R_BUS_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] to_cnt;

   // Held at zero outside GRANT, so it is already clear on GRANT entry.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         to_cnt <= '0;
      end else if (state != GRANT) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         s_valid     <= 1'b0;
         s_addr      <= '0;
         m_ready     <= '0;
         // NOTE: the per-channel data array is reset explicitly because its
         // post-reset value of zero is observable on m_data.
         m_data      <= '0;
         grant_id    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  s_addr   <= m_addr[pick_idx];
                  s_valid  <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // A response arriving on the timeout cycle still completes normally.
               if (s_ready) begin
                  s_valid           <= 1'b0;
                  m_data[grant_id]  <= s_data;
                  m_ready[grant_id] <= 1'b1;
                  state             <= RESP;
               end else if (to_hit) begin
                  s_valid           <= 1'b0;
                  m_data[grant_id]  <= '1;
                  m_ready[grant_id] <= 1'b1;
                  timeout_err       <= 1'b1;
                  state             <= RESP;
               end
            end
            RESP: begin
               m_ready <= '0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_r_bus_arbiter.sv
// Self-checking bench for r_bus_arbiter: directed scenarios plus a randomized
// phase, all observed through a cycle-level behavioural model of the read bus.
module tb_r_bus_arbiter;

   localparam int DW     = 32;
   localparam int DEPTH  = 256;
   localparam int NCH    = 4;
   localparam int AW     = 8;
   localparam int CW     = 2;
   localparam int TO_CYC = 16;

   logic                    clk = 1'b0;
   logic                    n_rst;
   logic [NCH-1:0]          m_valid;
   logic [NCH-1:0][AW-1:0]  m_addr;
   logic [NCH-1:0]          m_ready;
   logic [NCH-1:0][DW-1:0]  m_data;
   logic                    s_valid;
   logic [AW-1:0]           s_addr;
   logic                    s_ready;
   logic [DW-1:0]           s_data;
   logic [CW-1:0]           grant_id;
   logic                    busy;
   logic                    timeout_err;

   r_bus_arbiter #(
      .DATA_WIDTH     (DW),
      .RAM_DEPTH      (DEPTH),
      .NUM_CH         (NCH),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .m_valid     (m_valid),
      .m_addr      (m_addr),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .s_valid     (s_valid),
      .s_addr      (s_addr),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model of the bus: who is being served, what each master should hold.
   bit            mon_en;
   logic          pv_sv;
   logic          pv_mr;
   int            model_last;
   int            model_g;
   int            gcyc;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] exp_md [NCH];
   int            glog [$];
   int            gcy [$];
   int            to_pulses;

   bit auto_m, auto_s;
   int p_req, p_drop, p_ready;

   function automatic int rr_next(input logic [NCH-1:0] vec, input int last);
      for (int k = 1; k <= NCH; k++) begin
         if (vec[(last + k) % NCH]) return (last + k) % NCH;
      end
      return -1;
   endfunction

   task automatic model_reset();
      model_last = NCH - 1;
      model_g    = 0;
      gcyc       = 0;
      pv_sv      = 1'b0;
      pv_mr      = 1'b0;
      for (int i = 0; i < NCH; i++) exp_md[i] = '0;
   endtask

   // Called at the falling edge: inputs still hold what the last rising edge sampled.
   task automatic monitor();
      logic           exp_sv;
      logic           to;
      logic [NCH-1:0] exp_mr;
      cyc++;
      if (!mon_en) return;
      exp_sv = 1'b0;
      exp_mr = '0;
      to     = 1'b0;
      if (pv_sv) begin
         gcyc++;
         if (s_ready) begin
            exp_mr[model_g] = 1'b1;
            exp_md[model_g] = s_data;
         end
`ifdef R_BUS_ARB_TIMEOUT_EN
         else if (gcyc == TO_CYC) begin
            to              = 1'b1;
            exp_mr[model_g] = 1'b1;
            exp_md[model_g] = '1;
         end
`endif
         exp_sv = (exp_mr == '0);
      end else if (!pv_mr && m_valid != '0) begin
         model_g    = rr_next(m_valid, model_last);
         model_last = model_g;
         g_addr     = m_addr[model_g];
         gcyc       = 0;
         exp_sv     = 1'b1;
         glog.push_back(model_g);
         gcy.push_back(cyc);
      end
      check("s_valid", s_valid, exp_sv);
      if (exp_sv) check("s_addr", s_addr, g_addr);
      check("grant_id", grant_id, model_g);
      check("m_ready", m_ready, exp_mr);
      for (int i = 0; i < NCH; i++) check($sformatf("m_data%0d", i), m_data[i], exp_md[i]);
      check("busy", busy, exp_sv || (exp_mr != '0));
      check("timeout_err", timeout_err, to);
      if (timeout_err) to_pulses++;
      pv_sv = s_valid;
      pv_mr = |m_ready;
   endtask

   task automatic drive_m();
      for (int i = 0; i < NCH; i++) begin
         if (m_ready[i]) begin
            m_valid[i] = 1'b0;
         end else if (!m_valid[i]) begin
            if ($urandom_range(99) < p_req) begin
               m_valid[i] = 1'b1;
               m_addr[i]  = AW'($urandom);
            end
         end else if (!(s_valid && model_g == i) && $urandom_range(99) < p_drop) begin
            m_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic drive_s();
      if (s_valid) s_ready = ($urandom_range(99) < p_ready);
      else         s_ready = 1'($urandom_range(1));
      s_data = $urandom;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      if (auto_m) drive_m();
      if (auto_s) drive_s();
   endtask

   task automatic do_reset();
      n_rst   = 1'b0;
      mon_en  = 1'b0;
      m_valid = '0;
      s_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_s_valid", s_valid, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_m_ready", m_ready, 0);
      check("rst_m_data", m_data, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      n_rst = 1'b1;
      model_reset();
      mon_en = 1'b1;
   endtask

   task automatic drain();
      auto_m  = 1'b0;
      auto_s  = 1'b1;
      p_ready = 100;
      m_valid = '0;
      for (int k = 0; k < 50 && (busy || s_valid); k++) step();
      step();
      check("drain_idle", busy, 0);
      auto_s  = 1'b0;
      s_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      m_addr  = '0;
      s_data  = '0;
      auto_m  = 1'b0;
      auto_s  = 1'b0;
      p_req   = 0;
      p_drop  = 0;
      p_ready = 0;
      to_pulses = 0;
      model_reset();
      do_reset();

      // Single request on ch2, slave answers in the grant cycle.
      m_valid   = 4'b0100;
      m_addr[2] = 8'h3C;
      step();
      check("single_s_addr", s_addr, 8'h3C);
      s_ready = 1'b1;
      s_data  = 32'hDEADBEEF;
      step();
      check("single_m_ready", m_ready, 4'b0100);
      check("single_m_data", m_data[2], 32'hDEADBEEF);
      s_ready = 1'b0;
      m_valid = '0;
      step();
      step();

      // All channels requesting continuously from a fresh reset.
      do_reset();
      glog.delete();
      gcy.delete();
      auto_m  = 1'b1;
      auto_s  = 1'b1;
      p_req   = 100;
      p_drop  = 0;
      p_ready = 100;
      m_valid = '1;
      for (int k = 0; k < 40 && glog.size() < 5; k++) step();
      check("rr_count", glog.size() >= 5, 1);
      if (glog.size() >= 5) begin
         for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), glog[k], k % NCH);
         for (int k = 1; k < 5; k++) check($sformatf("rr_spacing%0d", k), gcy[k] - gcy[k-1], 3);
      end
      drain();

      // Slave stall on ch1.
      do_reset();
      m_valid   = 4'b0010;
      m_addr[1] = 8'hA7;
      s_ready   = 1'b0;
      step();
      for (int k = 0; k < 7; k++) begin
         step();
         check("stall_s_valid", s_valid, 1);
         check("stall_s_addr", s_addr, 8'hA7);
         check("stall_busy", busy, 1);
      end
      s_ready = 1'b1;
      s_data  = 32'h1234_5678;
      step();
      check("stall_m_ready", m_ready, 4'b0010);
      check("stall_m_data", m_data[1], 32'h1234_5678);
      s_ready = 1'b0;
      m_valid = '0;
      step();

      // Pointer skip: last served is ch1, so ch3 goes before ch0.
      m_valid   = 4'b1001;
      m_addr[0] = 8'h01;
      m_addr[3] = 8'h03;
      step();
      check("skip_first", grant_id, 3);
      s_ready = 1'b1;
      step();
      m_valid[3] = 1'b0;
      s_ready    = 1'b0;
      step();
      step();
      check("skip_second", grant_id, 0);
      s_ready = 1'b1;
      step();
      m_valid = '0;
      s_ready = 1'b0;
      step();
      step();

      // Reset while ch3 is granted and ch1 waits.
      m_valid   = 4'b1000;
      m_addr[3] = 8'h11;
      step();
      check("prerst_grant", grant_id, 3);
      m_valid[1] = 1'b1;
      m_addr[1]  = 8'h22;
      step();
      #2 n_rst = 1'b0;
      #1;
      check("midrst_s_valid", s_valid, 0);
      check("midrst_m_ready", m_ready, 0);
      check("midrst_busy", busy, 0);
      mon_en = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      model_reset();
      mon_en = 1'b1;
      step();
      check("postrst_grant", grant_id, 1);
      check("postrst_s_addr", s_addr, 8'h22);
      s_ready = 1'b1;
      s_data  = 32'hCAFE_0001;
      step();
      m_valid[1] = 1'b0;
      s_ready    = 1'b0;
      step();
      step();
      check("postrst_next", grant_id, 3);
      s_ready = 1'b1;
      step();
      m_valid = '0;
      s_ready = 1'b0;
      step();
      step();

`ifdef R_BUS_ARB_TIMEOUT_EN
      // Slave never answers ch0.
      begin
         int svn;
         svn       = 0;
         to_pulses = 0;
         m_valid   = 4'b0001;
         m_addr[0] = 8'h5A;
         s_ready   = 1'b0;
         for (int k = 0; k < 40 && m_ready[0] !== 1'b1; k++) begin
            step();
            if (s_valid) svn++;
         end
         check("to_m_ready", m_ready[0], 1);
         check("to_m_data", m_data[0], {DW{1'b1}});
         check("to_grant_cycles", svn, TO_CYC);
         m_valid = '0;
         step();
         step();
         check("to_pulses", to_pulses, 1);
         check("to_idle", busy, 0);
      end
`endif

      // Randomized traffic.
      to_pulses = 0;
      auto_m  = 1'b1;
      auto_s  = 1'b1;
      p_req   = 30;
      p_drop  = 5;
      p_ready = 40;
      for (int k = 0; k < 2500; k++) step();
      check("rand_grants", glog.size() > 200, 1);
      drain();
`ifndef R_BUS_ARB_TIMEOUT_EN
      check("no_timeout", to_pulses, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
